// File: rtl/debounce_sync_pkg.sv
// rtl/debounce_sync_pkg.sv - shared state encoding and default constants for debounce_sync
package debounce_sync_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_sync_sync_ff.sv
// rtl/debounce_sync_sync_ff.sv - N-stage single-bit synchronizer, async reset to INIT_LEVEL
module sync_ff #(
    parameter int   STAGES     = 2,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizes a raw level and accepts a change only after it holds
// DEBOUNCE_CYCLES consecutive clocks; abandoned changes raise a one-cycle glitch pulse.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic INIT_LEVEL      = 1'b0,
    localparam int  CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out,
    output logic busy,
    output logic glitch
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             d_sync;
    logic             mismatch;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             glitch_q, glitch_d;

    sync_ff #(
        .STAGES     (SYNC_STAGES),
        .INIT_LEVEL (INIT_LEVEL)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (d_in),
        .q_o   (d_sync)
    );

    assign mismatch = (d_sync != d_out_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            d_out_q  <= INIT_LEVEL;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_out_q  <= d_out_d;
            glitch_q <= glitch_d;
        end
    end

    // cnt counts mismatching samples already seen; the sample that reaches
    // DEBOUNCE_CYCLES toggles d_out on the same edge instead of incrementing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_out_d  = d_out_q;
        glitch_d = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (mismatch) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        d_out_d = ~d_out_q;
                    end else begin
                        state_d = ST_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (!mismatch) begin
                    glitch_d = 1'b1;
                    state_d  = ST_STABLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    d_out_d = ~d_out_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        d_out  = d_out_q;
        busy   = (state_q == ST_QUALIFY);
        glitch = glitch_q;
    end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed self-checking bench for debounce_sync at default parameters
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst;
    logic d_in;
    logic d_out;
    logic busy;
    logic glitch;

    int   checks   = 0;
    int   errors   = 0;
    int   toggles  = 0;
    int   glitches = 0;
    logic prev     = 1'b0;

    always #5 clk = ~clk;

    debounce_sync dut (
        .clk    (clk),
        .rst    (rst),
        .d_in   (d_in),
        .d_out  (d_out),
        .busy   (busy),
        .glitch (glitch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, tally d_out transitions and glitch pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (d_out !== prev) toggles++;
        prev = d_out;
        if (glitch === 1'b1) glitches++;
    endtask

    task automatic clr();
        toggles  = 0;
        glitches = 0;
        prev     = d_out;
    endtask

    task automatic seq(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            d_in = bits[i];
            tick();
        end
    endtask

    initial begin
        rst  = 1'b1;
        d_in = 1'b1;
        #1;
        clr();
        tick();
        tick();
        chk("rst_d_out", d_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_glitch", glitch, 0);

        // d_in already high at release: d_out rises on the 6th edge
        rst = 1'b0;
        clr();
        tick();
        tick();
        chk("rel_busy_e2", busy, 0);
        tick();
        chk("rel_busy_e3", busy, 1);
        tick();
        tick();
        chk("rel_busy_e5", busy, 1);
        chk("rel_d_out_e5", d_out, 0);
        tick();
        chk("rel_d_out_e6", d_out, 1);
        chk("rel_busy_e6", busy, 0);
        chk("rel_glitches", glitches, 0);

        // held falling then rising change, k+5 latency each way
        clr();
        d_in = 1'b0;
        repeat (5) tick();
        chk("fall_d_out_k4", d_out, 1);
        tick();
        chk("fall_d_out_k5", d_out, 0);
        d_in = 1'b1;
        repeat (5) tick();
        chk("rise_d_out_k4", d_out, 0);
        tick();
        chk("rise_d_out_k5", d_out, 1);
        repeat (4) tick();
        chk("hold_toggles", toggles, 2);
        chk("hold_glitches", glitches, 0);
        d_in = 1'b0;
        repeat (10) tick();
        chk("back_low", d_out, 0);

        // 2-cycle pulse: abandoned, one glitch, busy drops with it
        clr();
        d_in = 1'b1;
        tick();
        tick();
        d_in = 1'b0;
        tick();
        chk("p2_busy", busy, 1);
        tick();
        chk("p2_glitch_early", glitch, 0);
        tick();
        chk("p2_glitch", glitch, 1);
        chk("p2_busy_fall", busy, 0);
        tick();
        chk("p2_glitch_width", glitch, 0);
        repeat (4) tick();
        chk("p2_toggles", toggles, 0);
        chk("p2_glitches", glitches, 1);
        chk("p2_d_out", d_out, 0);

        // 3-cycle pulse rejected, 4-cycle pulse accepted, then low held
        clr();
        seq(32'h7, 3);
        seq(32'h0, 8);
        chk("p3_toggles", toggles, 0);
        chk("p3_glitches", glitches, 1);
        clr();
        seq(32'hF, 4);
        d_in = 1'b0;
        tick();
        chk("p4_d_out_k4", d_out, 0);
        tick();
        chk("p4_d_out_k5", d_out, 1);
        repeat (3) tick();
        chk("p4_d_out_hold", d_out, 1);
        tick();
        chk("p4_fall_k5", d_out, 0);
        tick();
        tick();
        chk("p4_toggles", toggles, 2);
        chk("p4_glitches", glitches, 0);

        // reset mid-qualification with d_out = 1: async force to INIT_LEVEL, no glitch
        d_in = 1'b1;
        repeat (8) tick();
        chk("pre_rst_d_out", d_out, 1);
        d_in = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_d_out_hold", d_out, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_d_out", d_out, 0);
        chk("async_busy", busy, 0);
        chk("async_glitch", glitch, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        repeat (8) tick();
        chk("post_rst_glitches", glitches, 0);
        chk("post_rst_toggles", toggles, 0);
        chk("post_rst_busy", busy, 0);

        // bouncy press and release: exactly two accepted transitions
        clr();
        seq(32'h15, 6);
        seq(32'hFF, 8);
        seq(32'hA, 4);
        seq(32'h0, 8);
        tick();
        tick();
        chk("bounce_toggles", toggles, 2);
        chk("bounce_glitches", glitches, 5);
        chk("bounce_d_out", d_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
